// File: rtl/gamepad_pmod_multi_if.sv
// Bundle of the serial PMOD pins and the decoded controller outputs for
// gamepad_pmod_multi.
//   master : drives pmod_data/pmod_clk/pmod_latch, observes the decoded outputs
//   slave  : the decoder; samples the pins and drives buttons, present,
//            pressed, released, frame_valid, frame_err and stale
interface gamepad_pmod_multi_if #(
  parameter int NUM_PADS     = 2,
  parameter int BITS_PER_PAD = 12
);
  localparam int TOTAL = NUM_PADS * BITS_PER_PAD;

  logic                pmod_data;
  logic                pmod_clk;
  logic                pmod_latch;
  logic [TOTAL-1:0]    buttons;
  logic [NUM_PADS-1:0] present;
  logic [TOTAL-1:0]    pressed;
  logic [TOTAL-1:0]    released;
  logic                frame_valid;
  logic                frame_err;
  logic                stale;

  modport master (
    output pmod_data, pmod_clk, pmod_latch,
    input  buttons, present, pressed, released, frame_valid, frame_err, stale
  );

  modport slave (
    input  pmod_data, pmod_clk, pmod_latch,
    output buttons, present, pressed, released, frame_valid, frame_err, stale
  );
endinterface

// File: rtl/gamepad_pmod_multi.sv
// Decoder for a chain of NUM_PADS serial gamepads on a PMOD connector.
// The asynchronous pins are synchronised, pmod_clk rising edges shift data
// into a TOTAL-bit register and pmod_latch rising edges commit a frame when
// exactly TOTAL bits were received. A watchdog forces all pads to
// "disconnected" if no valid frame arrives within TIMEOUT_CYCLES.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   pmod   slave side of gamepad_pmod_multi_if
//          (pins in; buttons/present/pressed/released/frame_valid/
//           frame_err/stale out)
module gamepad_pmod_multi #(
  parameter int NUM_PADS       = 2,
  parameter int BITS_PER_PAD   = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gamepad_pmod_multi_if.slave   pmod
);

  localparam int TOTAL = NUM_PADS * BITS_PER_PAD;
  localparam int CNT_W = $clog2(TOTAL + 2);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOTAL + 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + 1'b1;
  endfunction

  function automatic logic [WD_W-1:0] wd_inc(input logic [WD_W-1:0] c);
    return (c == WD_MAX) ? c : c + 1'b1;
  endfunction

  // An unplugged pad leaves the data line pulled high: all-ones slice.
  function automatic logic [NUM_PADS-1:0] pad_present(input logic [TOTAL-1:0] f);
    logic [NUM_PADS-1:0] r;
    r = '0;
    for (int p = 0; p < NUM_PADS; p++)
      r[p] = ~&f[p*BITS_PER_PAD +: BITS_PER_PAD];
    return r;
  endfunction

  function automatic logic [TOTAL-1:0] mask_absent(input logic [TOTAL-1:0] f);
    logic [TOTAL-1:0]    r;
    logic [NUM_PADS-1:0] pr;
    pr = pad_present(f);
    r  = '0;
    for (int p = 0; p < NUM_PADS; p++)
      if (pr[p]) r[p*BITS_PER_PAD +: BITS_PER_PAD] = f[p*BITS_PER_PAD +: BITS_PER_PAD];
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] data_sync_p0, clk_sync_p0, latch_sync_p0;
  logic                   clk_hist_p1, latch_hist_p1;
  logic [TOTAL-1:0]       shift_reg, frame_reg;
  logic [CNT_W-1:0]       bit_cnt;
  logic [WD_W-1:0]        wd_cnt;
  logic [TOTAL-1:0]       buttons_p2, pressed_p2, released_p2;
  logic [NUM_PADS-1:0]    present_p2;
  logic                   vld_p2, err_p2, stale_p2;

  logic             data_s, clk_s, latch_s;
  logic             clk_rise, latch_rise;
  logic             frame_ok, frame_bad, timeout_hit;
  logic [TOTAL-1:0] frame_next, buttons_next;

  // Stage p0 -> p1: synchronised pins, edge detect against delayed copy
  assign data_s     = data_sync_p0[SYNC_STAGES-1];
  assign clk_s      = clk_sync_p0[SYNC_STAGES-1];
  assign latch_s    = latch_sync_p0[SYNC_STAGES-1];
  assign clk_rise   = clk_s & ~clk_hist_p1;
  assign latch_rise = latch_s & ~latch_hist_p1;

  // Stage p1 -> p2: frame commit / timeout and output decode
  assign frame_ok    = latch_rise && (bit_cnt == CNT_FULL);
  assign frame_bad   = latch_rise && (bit_cnt != CNT_FULL);
  assign timeout_hit = !frame_ok && (wd_cnt == WD_LAST);
  assign frame_next  = frame_ok ? shift_reg : (timeout_hit ? '1 : frame_reg);
  assign buttons_next = mask_absent(frame_next);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_sync_p0  <= '0;
      clk_sync_p0   <= '0;
      latch_sync_p0 <= '0;
      clk_hist_p1   <= 1'b0;
      latch_hist_p1 <= 1'b0;
      bit_cnt       <= '0;
      wd_cnt        <= '0;
      shift_reg     <= '1;
      frame_reg     <= '1;
      buttons_p2    <= '0;
      present_p2    <= '0;
      pressed_p2    <= '0;
      released_p2   <= '0;
      vld_p2        <= 1'b0;
      err_p2        <= 1'b0;
      stale_p2      <= 1'b1;
    end else begin
      data_sync_p0  <= {data_sync_p0[SYNC_STAGES-2:0], pmod.pmod_data};
      clk_sync_p0   <= {clk_sync_p0[SYNC_STAGES-2:0], pmod.pmod_clk};
      latch_sync_p0 <= {latch_sync_p0[SYNC_STAGES-2:0], pmod.pmod_latch};
      clk_hist_p1   <= clk_s;
      latch_hist_p1 <= latch_s;

      // A latch edge swallows a coincident clk edge.
      if (latch_rise) begin
        bit_cnt <= '0;
      end else if (clk_rise) begin
        shift_reg <= {shift_reg[TOTAL-2:0], data_s};
        bit_cnt   <= cnt_inc(bit_cnt);
      end

      wd_cnt    <= frame_ok ? '0 : wd_inc(wd_cnt);
      frame_reg <= frame_next;

      // Edge events are zero whenever buttons_next equals the held value.
      buttons_p2  <= buttons_next;
      present_p2  <= pad_present(frame_next);
      pressed_p2  <= buttons_next & ~buttons_p2;
      released_p2 <= ~buttons_next & buttons_p2;
      vld_p2      <= frame_ok;
      err_p2      <= frame_bad;
      if (frame_ok)         stale_p2 <= 1'b0;
      else if (timeout_hit) stale_p2 <= 1'b1;
    end
  end

  assign pmod.buttons     = buttons_p2;
  assign pmod.present     = present_p2;
  assign pmod.pressed     = pressed_p2;
  assign pmod.released    = released_p2;
  assign pmod.frame_valid = vld_p2;
  assign pmod.frame_err   = err_p2;
  assign pmod.stale       = stale_p2;

endmodule

// File: tb/tb_gamepad_pmod_multi.sv
// Self-checking bench for gamepad_pmod_multi (2 pads x 12 bits, 2 sync
// stages, 64-cycle timeout). A behavioural model tracks the bits sent since
// the last latch, the committed frame and the cycles since the last valid
// frame, and every output is compared against it at the check points.
module tb_gamepad_pmod_multi;
  localparam int NUM_PADS = 2;
  localparam int BPP      = 12;
  localparam int TOTAL    = NUM_PADS * BPP;
  localparam int TIMEOUT  = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  gamepad_pmod_multi_if #(.NUM_PADS(NUM_PADS), .BITS_PER_PAD(BPP)) pmod_if ();

  gamepad_pmod_multi #(
    .NUM_PADS(NUM_PADS), .BITS_PER_PAD(BPP), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pmod (pmod_if)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [TOTAL-1:0]    m_frame, m_buttons, m_pressed, m_released;
  logic [NUM_PADS-1:0] m_present;
  logic                m_valid, m_err, m_stale;
  int                  m_since;
  bit                  m_bits[$];

  int checks = 0;
  int passed = 0;

  function automatic logic [TOTAL-1:0] masked(input logic [TOTAL-1:0] f);
    logic [TOTAL-1:0] r;
    r = f;
    for (int p = 0; p < NUM_PADS; p++)
      if (f[p*BPP +: BPP] == {BPP{1'b1}}) r[p*BPP +: BPP] = '0;
    return r;
  endfunction

  function automatic logic [NUM_PADS-1:0] pres(input logic [TOTAL-1:0] f);
    logic [NUM_PADS-1:0] r;
    for (int p = 0; p < NUM_PADS; p++) r[p] = (f[p*BPP +: BPP] != {BPP{1'b1}});
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".buttons"},     32'(pmod_if.buttons),     32'(m_buttons));
    chk({tag, ".present"},     32'(pmod_if.present),     32'(m_present));
    chk({tag, ".pressed"},     32'(pmod_if.pressed),     32'(m_pressed));
    chk({tag, ".released"},    32'(pmod_if.released),    32'(m_released));
    chk({tag, ".frame_valid"}, 32'(pmod_if.frame_valid), 32'(m_valid));
    chk({tag, ".frame_err"},   32'(pmod_if.frame_err),   32'(m_err));
    chk({tag, ".stale"},       32'(pmod_if.stale),       32'(m_stale));
  endtask

  // Advance one clock and update the model; do_latch marks the cycle in which
  // a latch edge raised three edges earlier becomes visible on the outputs.
  task automatic tick(input bit do_latch);
    logic [TOTAL-1:0] nf, nb;
    bit ok;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_frame = '1; m_buttons = '0; m_present = '0; m_pressed = '0; m_released = '0;
      m_valid = 1'b0; m_err = 1'b0; m_stale = 1'b1; m_since = 0;
      m_bits.delete();
      return;
    end
    nf = m_frame; ok = 1'b0; m_err = 1'b0;
    if (do_latch) begin
      if (m_bits.size() == TOTAL) begin
        ok = 1'b1;
        for (int i = 0; i < TOTAL; i++) nf[TOTAL-1-i] = m_bits[i];
      end else begin
        m_err = 1'b1;
      end
      m_bits.delete();
    end
    m_valid = ok;
    if (ok) begin
      m_since = 0;
      m_stale = 1'b0;
    end else begin
      m_since++;
      if (m_since == TIMEOUT) begin
        nf = '1;
        m_stale = 1'b1;
      end
    end
    nb = masked(nf);
    m_pressed  = nb & ~m_buttons;
    m_released = ~nb & m_buttons;
    m_buttons  = nb;
    m_present  = pres(nf);
    m_frame    = nf;
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    pmod_if.pmod_data = b;
    pmod_if.pmod_clk  = 1'b1;
    m_bits.push_back(b);
    tick(1'b0);
    @(negedge clk);
    pmod_if.pmod_clk = 1'b0;
    tick(1'b0);
  endtask

  task automatic send_frame(input logic [TOTAL-1:0] v, input int n);
    logic [TOTAL-1:0] vv;
    vv = v;
    for (int i = 0; i < n; i++) send_bit(vv[TOTAL-1-(i % TOTAL)]);
  endtask

  task automatic latch_and_check(input string tag);
    @(negedge clk);
    pmod_if.pmod_latch = 1'b1;
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    check_all({tag, "@edge"});
    tick(1'b0);
    check_all({tag, "@next"});
    @(negedge clk);
    pmod_if.pmod_latch = 1'b0;
    tick(1'b0);
  endtask

  // Latch and clk pins rise together; the model receives no extra bit.
  task automatic latch_with_clk(input string tag);
    @(negedge clk);
    pmod_if.pmod_data  = 1'b0;
    pmod_if.pmod_clk   = 1'b1;
    pmod_if.pmod_latch = 1'b1;
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    check_all({tag, "@edge"});
    tick(1'b0);
    check_all({tag, "@next"});
    @(negedge clk);
    pmod_if.pmod_clk   = 1'b0;
    pmod_if.pmod_latch = 1'b0;
    tick(1'b0);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick(1'b0);
      check_all(tag);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    pmod_if.pmod_clk   = 1'b0;
    pmod_if.pmod_latch = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) tick(1'b0);
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [TOTAL-1:0] v;
    logic [BPP-1:0]   pad;
    int               n;

    pmod_if.pmod_data  = 1'b0;
    pmod_if.pmod_clk   = 1'b0;
    pmod_if.pmod_latch = 1'b0;

    // Reset state
    do_reset(4);
    chk("reset.stale_const",   32'(pmod_if.stale),   32'd1);
    chk("reset.present_const", 32'(pmod_if.present), 32'd0);
    idle(3, "post_reset");

    // Pad 1 absent, pad 0 presses b
    send_frame(24'hFFF800, TOTAL);
    latch_and_check("f800");
    chk("f800.buttons_const", 32'(pmod_if.buttons), 32'h000800);
    chk("f800.present_const", 32'(pmod_if.present), 32'h1);
    chk("f800.stale_const",   32'(pmod_if.stale),   32'd0);

    // Release b
    send_frame(24'hFFF000, TOTAL);
    latch_and_check("f000");
    chk("f000.buttons_const", 32'(pmod_if.buttons), 32'h0);

    // Short and long frames leave outputs alone
    send_frame(24'h400400, TOTAL);
    latch_and_check("f400");
    send_frame(24'h123456, TOTAL - 1);
    latch_and_check("short");
    chk("short.buttons_const", 32'(pmod_if.buttons), 32'h400400);
    chk("short.present_const", 32'(pmod_if.present), 32'h3);
    send_frame(24'h400400, TOTAL);
    latch_and_check("f400b");
    send_frame(24'h654321, TOTAL + 1);
    latch_and_check("long");
    chk("long.buttons_const", 32'(pmod_if.buttons), 32'h400400);

    // Watchdog expiry and recovery
    send_frame(24'h400400, TOTAL);
    latch_and_check("f400c");
    idle(TIMEOUT + 4, "timeout");
    chk("timeout.stale_const",   32'(pmod_if.stale),   32'd1);
    chk("timeout.present_const", 32'(pmod_if.present), 32'h0);
    chk("timeout.buttons_const", 32'(pmod_if.buttons), 32'h0);
    send_frame(24'h001002, TOTAL);
    latch_and_check("recover");
    chk("recover.stale_const", 32'(pmod_if.stale), 32'd0);

    // Reset in the middle of a frame
    send_frame(24'hABCDEF, 10);
    do_reset(4);
    send_frame(24'hFFF001, TOTAL);
    latch_and_check("after_rst");
    chk("after_rst.buttons_const", 32'(pmod_if.buttons), 32'h000001);

    // Coincident latch and clk edges: the 24th clk must not count
    send_frame(24'h00F00F, TOTAL - 1);
    latch_with_clk("coincide");
    chk("coincide.buttons_const", 32'(pmod_if.buttons), 32'h000001);
    send_frame(24'h00F00F, TOTAL);
    latch_and_check("coincide_ok");

    // Randomised frames, lengths and idle gaps
    for (int k = 0; k < 10; k++) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        pad = BPP'($urandom);
        if ($urandom_range(0, 2) == 0) pad = '1;
        v[p*BPP +: BPP] = pad;
      end
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 27)) : TOTAL;
      send_frame(v, n);
      latch_and_check("rand");
      if ($urandom_range(0, 3) == 0) idle(TIMEOUT + 2, "rand_idle");
      else idle(int'($urandom_range(0, 5)), "rand_gap");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
